// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: read, write and reserve requests in; read data and scoreboard status out.
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    logic [ADDR_W-1:0] writeAddr;
    logic [DATA_W-1:0] writeData;
    logic              writeEn;
    logic              rsvEn;
    logic [ADDR_W-1:0] rsvAddr;
    logic [DATA_W-1:0] dataOut1;
    logic [DATA_W-1:0] dataOut2;
    logic              busy1;
    logic              busy2;
    logic [ADDR_W:0]   busyCount;
    logic              rsvErr;

    modport master (
        output addr1, addr2, writeAddr, writeData, writeEn, rsvEn, rsvAddr,
        input  dataOut1, dataOut2, busy1, busy2, busyCount, rsvErr
    );

    modport slave (
        input  addr1, addr2, writeAddr, writeData, writeEn, rsvEn, rsvAddr,
        output dataOut1, dataOut2, busy1, busy2, busyCount, rsvErr
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file with two registered read ports, one write port and a busy scoreboard.
// Define REGFILE_BYPASS_EN for write-through forwarding; default is read-before-write.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input logic         clk,
    input logic         rst_n,
    regfile_sb_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] entry [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;
    logic              armed;
    logic              wr_ok;
    logic              rsv_ok;
    logic              inc;
    logic              dec;
    logic              err_next;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    // The first edge after reset release is swallowed so outputs stay 0 and late requests are dropped.
    always_comb begin
        wr_ok  = armed && bus.writeEn && !(ZERO_REG && bus.writeAddr == '0);
        rsv_ok = armed && bus.rsvEn && !(ZERO_REG && bus.rsvAddr == '0);

        busy_next = busy;
        if (wr_ok)
            busy_next[bus.writeAddr] = 1'b0;
        if (rsv_ok)
            busy_next[bus.rsvAddr] = 1'b1;

        inc      = rsv_ok && !busy[bus.rsvAddr];
        dec      = wr_ok && busy[bus.writeAddr] && !(rsv_ok && bus.rsvAddr == bus.writeAddr);
        err_next = rsv_ok && busy[bus.rsvAddr] && !(wr_ok && bus.writeAddr == bus.rsvAddr);

        rd1 = entry[bus.addr1];
        rd2 = entry[bus.addr2];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && bus.writeAddr == bus.addr1)
            rd1 = bus.writeData;
        if (wr_ok && bus.writeAddr == bus.addr2)
            rd2 = bus.writeData;
`endif
        if (ZERO_REG && bus.addr1 == '0)
            rd1 = '0;
        if (ZERO_REG && bus.addr2 == '0)
            rd2 = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                entry[i] <= '0;
            busy          <= '0;
            armed         <= 1'b0;
            bus.dataOut1  <= '0;
            bus.dataOut2  <= '0;
            bus.busy1     <= 1'b0;
            bus.busy2     <= 1'b0;
            bus.busyCount <= '0;
            bus.rsvErr    <= 1'b0;
        end else if (!armed) begin
            armed <= 1'b1;
        end else begin
            if (wr_ok)
                entry[bus.writeAddr] <= bus.writeData;
            busy         <= busy_next;
            bus.dataOut1 <= rd1;
            bus.dataOut2 <= rd2;
            bus.busy1    <= busy_next[bus.addr1];
            bus.busy2    <= busy_next[bus.addr2];
            bus.rsvErr   <= err_next;
            // Only transitions move the counter, so a reserve and release on different entries cancel.
            case ({inc, dec})
                2'b10:   bus.busyCount <= bus.busyCount + 1'b1;
                2'b01:   bus.busyCount <= bus.busyCount - 1'b1;
                default: bus.busyCount <= bus.busyCount;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed, table-driven self-checking bench for regfile_sb (default ZERO_REG=1 build).
module tb_regfile_sb;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        rsv;
        logic [4:0]  ra;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        eb1;
        logic        eb2;
        logic [5:0]  ecnt;
        logic        eerr;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    vec_t vecs [17];

    regfile_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mk(input logic [4:0] a1, input logic [4:0] a2,
                                input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic rsv, input logic [4:0] ra,
                                input logic [31:0] e1, input logic [31:0] e2,
                                input logic eb1, input logic eb2,
                                input logic [5:0] ecnt, input logic eerr);
        vec_t v;
        v.a1 = a1; v.a2 = a2; v.we = we; v.wa = wa; v.wd = wd; v.rsv = rsv; v.ra = ra;
        v.e1 = e1; v.e2 = e2; v.eb1 = eb1; v.eb2 = eb2; v.ecnt = ecnt; v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] a1, input logic [4:0] a2,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic rsv, input logic [4:0] ra);
        bus.addr1 = a1; bus.addr2 = a2;
        bus.writeEn = we; bus.writeAddr = wa; bus.writeData = wd;
        bus.rsvEn = rsv; bus.rsvAddr = ra;
    endtask

    task automatic applyStimulus(input vec_t v);
        drive(v.a1, v.a2, v.we, v.wa, v.wd, v.rsv, v.ra);
        step();
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        chk({tag, ".dataOut1"}, 64'(bus.dataOut1), 64'(v.e1));
        chk({tag, ".dataOut2"}, 64'(bus.dataOut2), 64'(v.e2));
        chk({tag, ".busy1"}, 64'(bus.busy1), 64'(v.eb1));
        chk({tag, ".busy2"}, 64'(bus.busy2), 64'(v.eb2));
        chk({tag, ".busyCount"}, 64'(bus.busyCount), 64'(v.ecnt));
        chk({tag, ".rsvErr"}, 64'(bus.rsvErr), 64'(v.eerr));
    endtask

    task automatic checkZero(input string tag);
        chk({tag, ".dataOut1"}, 64'(bus.dataOut1), 64'h0);
        chk({tag, ".dataOut2"}, 64'(bus.dataOut2), 64'h0);
        chk({tag, ".busy1"}, 64'(bus.busy1), 64'h0);
        chk({tag, ".busy2"}, 64'(bus.busy2), 64'h0);
        chk({tag, ".busyCount"}, 64'(bus.busyCount), 64'h0);
        chk({tag, ".rsvErr"}, 64'(bus.rsvErr), 64'h0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //            a1 a2 we wa  wd            rsv ra  e1                            e2            b1 b2 cnt err
        vecs[0]  = mk(0, 0, 1, 7,  32'h12345678, 0,  0,  32'h0,                        32'h0,        0, 0, 0, 0);
        vecs[1]  = mk(7, 0, 1, 0,  32'hFFFFFFFF, 0,  0,  32'h12345678,                 32'h0,        0, 0, 0, 0);
        vecs[2]  = mk(0, 7, 0, 0,  32'h0,        0,  0,  32'h0,                        32'h12345678, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 1, 3,  32'h1,        0,  0,  32'h0,                        32'h0,        0, 0, 0, 0);
        vecs[4]  = mk(3, 7, 1, 3,  32'hA5A5A5A5, 0,  0,  BYP ? 32'hA5A5A5A5 : 32'h1,   32'h12345678, 0, 0, 0, 0);
        vecs[5]  = mk(3, 0, 0, 0,  32'h0,        0,  0,  32'hA5A5A5A5,                 32'h0,        0, 0, 0, 0);
        vecs[6]  = mk(4, 9, 0, 0,  32'h0,        1,  4,  32'h0,                        32'h0,        1, 0, 1, 0);
        vecs[7]  = mk(4, 9, 0, 0,  32'h0,        1,  9,  32'h0,                        32'h0,        1, 1, 2, 0);
        vecs[8]  = mk(4, 9, 1, 4,  32'h44,       0,  0,  BYP ? 32'h44 : 32'h0,         32'h0,        0, 1, 1, 0);
        vecs[9]  = mk(9, 4, 1, 9,  32'h99,       1,  9,  BYP ? 32'h99 : 32'h0,         32'h44,       1, 0, 1, 0);
        vecs[10] = mk(6, 9, 0, 0,  32'h0,        1,  6,  32'h0,                        32'h99,       1, 1, 2, 0);
        vecs[11] = mk(6, 9, 0, 0,  32'h0,        1,  6,  32'h0,                        32'h99,       1, 1, 2, 1);
        vecs[12] = mk(6, 9, 0, 0,  32'h0,        0,  0,  32'h0,                        32'h99,       1, 1, 2, 0);
        vecs[13] = mk(0, 6, 0, 0,  32'h0,        1,  0,  32'h0,                        32'h0,        0, 1, 2, 0);
        vecs[14] = mk(6, 9, 1, 6,  32'h66,       0,  0,  BYP ? 32'h66 : 32'h0,         32'h99,       0, 1, 1, 0);
        vecs[15] = mk(9, 6, 1, 9,  32'h1,        0,  0,  BYP ? 32'h1 : 32'h99,         32'h66,       0, 0, 0, 0);
        vecs[16] = mk(6, 9, 1, 6,  32'h77,       0,  0,  BYP ? 32'h77 : 32'h66,        32'h1,        0, 0, 0, 0);

        // Initial reset, then the swallowed first edge after release.
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #12;
        checkZero("reset_low");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checkZero("first_edge");

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d", i), vecs[i]);
        end

        // Saturation: reserve every non-zero entry, then release them all.
        for (int i = 1; i < 32; i++) begin
            drive(5'd31, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i));
            step();
            chk($sformatf("sat_rsv%0d.busyCount", i), 64'(bus.busyCount), 64'(i));
        end
        chk("sat.busy1_r31", 64'(bus.busy1), 64'h1);
        drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
        step();
        chk("sat_r0.busyCount", 64'(bus.busyCount), 64'd31);
        chk("sat_r0.rsvErr", 64'(bus.rsvErr), 64'h0);
        for (int i = 1; i < 32; i++) begin
            drive(5'd31, 5'd0, 1'b1, 5'(i), 32'(i), 1'b0, 5'd0);
            step();
            chk($sformatf("sat_rel%0d.busyCount", i), 64'(bus.busyCount), 64'(31 - i));
        end
        chk("sat.busy1_r31_released", 64'(bus.busy1), 64'h0);
        drive(5'd1, 5'd0, 1'b1, 5'd1, 32'h5, 1'b0, 5'd0);
        step();
        chk("sat_underflow.busyCount", 64'(bus.busyCount), 64'd0);

        // Mid-cycle reset after loading r5 and reserving r8.
        drive(5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd8);
        step();
        drive(5'd5, 5'd8, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        step();
        chk("pre_rst.dataOut1", 64'(bus.dataOut1), 64'hDEADBEEF);
        chk("pre_rst.busy2", 64'(bus.busy2), 64'h1);
        chk("pre_rst.busyCount", 64'(bus.busyCount), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkZero("mid_rst");
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step();
        checkZero("mid_rst_first_edge");
        step();
        chk("post_rst.dataOut1_r5", 64'(bus.dataOut1), 64'h0);
        chk("post_rst.busy2_r8", 64'(bus.busy2), 64'h0);
        chk("post_rst.busyCount", 64'(bus.busyCount), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
